// File: rtl/uart_program_loader.sv
// UART 8N1 program loader: receives bytes, packs them big-endian into 32-bit words and
// writes the words to consecutive instruction RAM addresses until the program is complete.
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned NUM_WORDS    = 16,
  parameter int unsigned IDLE_BITS    = 11,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [31:0] instr,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic        prog_ready,
  output logic        rxd_idle,
  output logic        frame_err
);

  localparam int unsigned TimerW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned QuietMax =
      ((IDLE_BITS > TIMEOUT_BITS) ? IDLE_BITS : TIMEOUT_BITS) * CLKS_PER_BIT;
  localparam int unsigned QuietW   = $clog2(QuietMax + 1);

  localparam logic [TimerW-1:0] HalfLast      = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimerW-1:0] BitLast       = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [QuietW-1:0] QuietSat      = QuietW'(QuietMax);
  localparam logic [QuietW-1:0] IdleThresh    = QuietW'(IDLE_BITS * CLKS_PER_BIT);
  localparam logic [QuietW-1:0] TimeoutThresh = QuietW'(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [3:0]        LastAddr      = 4'(NUM_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} rx_state_e;

  rx_state_e state_q, state_d;

  logic              rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic [QuietW-1:0] quiet_q, quiet_d;

  logic start_edge, half_hit, bit_hit, sample_data, byte_valid, stop_bad;

  logic        byte_valid_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] partial_q;
  logic [31:0] instr_q;
  logic        wr_en_q;
  logic [3:0]  word_cnt_q;
  logic        prog_ready_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  assign start_edge = rxd_prev_q & ~rxd_s_q;
  assign half_hit   = (timer_q == HalfLast);
  assign bit_hit    = (timer_q == BitLast);

  // RX FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // RX FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_edge) state_d = StStart;
      StStart: if (half_hit) state_d = rxd_s_q ? StIdle : StData;
      StData:  if (bit_hit && (bit_cnt_q == 3'd7)) state_d = StStop;
      StStop:  if (bit_hit) state_d = rxd_s_q ? StIdle : StBreak;
      // A low stop bit may be a break; wait for the line to recover before re-arming.
      StBreak: if (rxd_s_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RX FSM: outputs
  always_comb begin
    sample_data = (state_q == StData) && bit_hit;
    byte_valid  = (state_q == StStop) && bit_hit && rxd_s_q;
    stop_bad    = (state_q == StStop) && bit_hit && !rxd_s_q;
    rxd_idle    = (state_q == StIdle) && (quiet_q >= IdleThresh);
  end

  assign frame_err = stop_bad;

  // Bit timer, bit counter, shift register and line-quiet counter.
  always_comb begin
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    rx_byte_d = rx_byte_q;
    unique case (state_q)
      StStart: begin
        timer_d   = half_hit ? '0 : timer_q + TimerW'(1);
        bit_cnt_d = '0;
      end
      StData, StStop: timer_d = bit_hit ? '0 : timer_q + TimerW'(1);
      default:        timer_d = '0;
    endcase
    if (sample_data) begin
      rx_byte_d = {rxd_s_q, rx_byte_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if (!rxd_s_q) begin
      quiet_d = '0;
    end else if (quiet_q == QuietSat) begin
      quiet_d = quiet_q;
    end else begin
      quiet_d = quiet_q + QuietW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q   <= '0;
      bit_cnt_q <= '0;
      rx_byte_q <= '0;
      quiet_q   <= '0;
    end else begin
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      rx_byte_q <= rx_byte_d;
      quiet_q   <= quiet_d;
    end
  end

  // Byte packer and RAM write sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_valid_q <= 1'b0;
      byte_idx_q   <= '0;
      partial_q    <= '0;
      instr_q      <= '0;
      wr_en_q      <= 1'b0;
      word_cnt_q   <= '0;
      prog_ready_q <= 1'b0;
    end else begin
      byte_valid_q <= byte_valid;
      wr_en_q      <= 1'b0;

      // Counter holds at the last address once the program is complete.
      if (wr_en_q) begin
        if (word_cnt_q == LastAddr) begin
          prog_ready_q <= 1'b1;
        end else begin
          word_cnt_q <= word_cnt_q + 4'd1;
        end
      end

      if (byte_valid_q && !prog_ready_q) begin
        unique case (byte_idx_q)
          2'd0: partial_q[23:16] <= rx_byte_q;
          2'd1: partial_q[15:8]  <= rx_byte_q;
          2'd2: partial_q[7:0]   <= rx_byte_q;
          2'd3: begin
            instr_q <= {partial_q, rx_byte_q};
            wr_en_q <= 1'b1;
          end
          default: ;
        endcase
        byte_idx_q <= byte_idx_q + 2'd1;
      end else if ((byte_idx_q != 2'd0) && (quiet_q >= TimeoutThresh)) begin
        byte_idx_q <= '0;
      end
    end
  end

  assign instr      = instr_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = word_cnt_q;
  assign prog_ready = prog_ready_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader at 16 clocks per bit and a 16-word program.
module tb_uart_program_loader;

  localparam int unsigned Cpb = 16;

  logic        clk;
  logic        rst;
  logic        rxd;
  logic [31:0] instr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic        prog_ready;
  logic        rxd_idle;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  logic [3:0]  wq_addr[$];
  logic [31:0] wq_instr[$];
  int fe_count   = 0;
  int wr_run     = 0;
  int wr_run_max = 0;
  int fe_run     = 0;
  int fe_run_max = 0;

  uart_program_loader #(
    .CLKS_PER_BIT(Cpb),
    .NUM_WORDS   (16),
    .IDLE_BITS   (11),
    .TIMEOUT_BITS(40)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .instr     (instr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .prog_ready(prog_ready),
    .rxd_idle  (rxd_idle),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RAM write and pulse widths, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_instr.push_back(instr);
    end
    if (frame_err) fe_count++;
    wr_run = wr_en ? wr_run + 1 : 0;
    if (wr_run > wr_run_max) wr_run_max = wr_run;
    fe_run = frame_err ? fe_run + 1 : 0;
    if (fe_run > fe_run_max) fe_run_max = fe_run;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame with start_cycles of start bit still to send (the rest is a full 8N1 frame).
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int start_cycles);
    rxd = 1'b0;
    repeat (start_cycles) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (Cpb) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (Cpb) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] data);
    send_frame(data, 1'b1, Cpb);
  endtask

  task automatic do_reset();
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int base;

    rst = 1'b1;
    rxd = 1'b1;
    #1 rst = 1'b0;
    #2;
    check_eq("reset_instr", instr, 32'h0);
    check_eq("reset_wr_en", {31'b0, wr_en}, 32'h0);
    check_eq("reset_wr_addr", {28'b0, wr_addr}, 32'h0);
    check_eq("reset_prog_ready", {31'b0, prog_ready}, 32'h0);
    check_eq("reset_rxd_idle", {31'b0, rxd_idle}, 32'h0);
    check_eq("reset_frame_err", {31'b0, frame_err}, 32'h0);

    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Line idle detection: 11 bit-times of high line.
    cnt = 0;
    while (!rxd_idle && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("idle_rise_time", {31'b0, (cnt >= 173 && cnt <= 179)}, 32'h1);

    // Start bit of the first program byte: idle drops when the FSM leaves IDLE.
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_before_start", {31'b0, rxd_idle}, 32'h1);
    @(negedge clk);
    check_eq("idle_after_start", {31'b0, rxd_idle}, 32'h0);
    send_frame(8'hA0, 1'b1, Cpb - 3);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    for (int k = 1; k < 16; k++) begin
      send_byte(8'hA0 + 8'(k));
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      if (k == 14) check_eq("not_ready_at_15", {31'b0, prog_ready}, 32'h0);
    end
    check_eq("load_write_count", wq_addr.size(), 16);
    for (int k = 0; k < 16 && k < wq_addr.size(); k++) begin
      check_eq($sformatf("load_addr_%0d", k), {28'b0, wq_addr[k]}, k);
      check_eq($sformatf("load_instr_%0d", k), wq_instr[k], 32'hA0112233 + (k << 24));
    end
    check_eq("wr_en_width", wr_run_max, 1);
    check_eq("ready_after_load", {31'b0, prog_ready}, 32'h1);
    check_eq("addr_after_load", {28'b0, wr_addr}, 32'hF);

    // Bytes after ready are ignored.
    repeat (4) send_byte(8'hFF);
    check_eq("post_ready_writes", wq_addr.size(), 16);
    check_eq("post_ready_hold", {31'b0, prog_ready}, 32'h1);
    check_eq("post_ready_addr", {28'b0, wr_addr}, 32'hF);

    // Inter-byte timeout drops a partial word.
    do_reset();
    check_eq("rst_clears_ready", {31'b0, prog_ready}, 32'h0);
    base = wq_addr.size();
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (40 * Cpb + 20) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check_eq("timeout_write_count", wq_addr.size() - base, 1);
    if (wq_addr.size() > base) begin
      check_eq("timeout_addr", {28'b0, wq_addr[base]}, 32'h0);
      check_eq("timeout_instr", wq_instr[base], 32'h01020304);
    end

    // Bad stop bit, then a short glitch; neither advances the packer.
    send_frame(8'h5A, 1'b0, Cpb);
    check_eq("frame_err_count", fe_count, 1);
    check_eq("frame_err_width", fe_run_max, 1);
    rxd = 1'b0;
    repeat (Cpb / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * Cpb) @(negedge clk);
    check_eq("glitch_no_err", fe_count, 1);
    base = wq_addr.size();
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    check_eq("align_write_count", wq_addr.size() - base, 1);
    if (wq_addr.size() > base) begin
      check_eq("align_addr", {28'b0, wq_addr[base]}, 32'h1);
      check_eq("align_instr", wq_instr[base], 32'h10203040);
    end

    // Reset in the middle of byte 3 of word 5.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h50 + 8'(k));
      send_byte(8'h61);
      send_byte(8'h62);
      send_byte(8'h63);
    end
    send_byte(8'h55);
    send_byte(8'h66);
    check_eq("pre_abort_addr", {28'b0, wr_addr}, 32'h5);
    rxd = 1'b0;
    repeat (Cpb + Cpb / 2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_instr", instr, 32'h0);
    check_eq("abort_wr_en", {31'b0, wr_en}, 32'h0);
    check_eq("abort_wr_addr", {28'b0, wr_addr}, 32'h0);
    check_eq("abort_prog_ready", {31'b0, prog_ready}, 32'h0);
    check_eq("abort_rxd_idle", {31'b0, rxd_idle}, 32'h0);
    check_eq("abort_frame_err", {31'b0, frame_err}, 32'h0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    base = wq_addr.size();
    send_byte(8'hC0);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    check_eq("restart_write_count", wq_addr.size() - base, 1);
    if (wq_addr.size() > base) begin
      check_eq("restart_addr", {28'b0, wq_addr[base]}, 32'h0);
      check_eq("restart_instr", wq_instr[base], 32'hC0C1C2C3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
